// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the branch predictor slice.
// No logic; counter state encodings and default widths only.
// Imported by branch_predictor and sat_counter2.
package branch_predictor_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int IDX_W_DEF      = 4;

    typedef logic [1:0] ctr_t;

    // 2-bit direction counter encodings: MSB set means predict taken
    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_WNT = 2'b01;
    localparam ctr_t CTR_WT  = 2'b10;
    localparam ctr_t CTR_ST  = 2'b11;

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating up/down counter next-state logic with parallel load.
// Latency: purely combinational, zero cycles.
// Backpressure: none; caller decides when the result is written.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  ctr_t ctr_cur,
    input  logic inc,
    input  logic load,
    input  ctr_t load_val,
    output ctr_t ctr_nxt
);

    // Load wins; otherwise step toward the outcome, clamping at both ends
    always_comb begin
        ctr_nxt = ctr_cur;
        if (load) begin
            ctr_nxt = load_val;
        end else if (inc) begin
            if (ctr_cur != CTR_ST) ctr_nxt = ctr_cur + 2'd1;
        end else begin
            if (ctr_cur != CTR_SNT) ctr_nxt = ctr_cur - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: IF lookup, EX resolve/update, perf counters.
// Latency: lookup and mispredict are combinational; table update lands on the next edge.
// Backpressure: none; one lookup and one update accepted every cycle.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int IDX_W      = IDX_W_DEF
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] if_pc,
    output logic                  pred_taken,
    output logic [DATA_WIDTH-1:0] pred_target,
    input  logic                  ex_valid,
    input  logic [DATA_WIDTH-1:0] ex_pc,
    input  logic                  ex_is_branch,
    input  logic                  ex_is_jal,
    input  logic                  ex_taken,
    input  logic [DATA_WIDTH-1:0] ex_target,
    input  logic                  ex_pred_taken,
    input  logic [DATA_WIDTH-1:0] ex_pred_target,
    output logic                  mispredict,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic [31:0]           br_cnt,
    output logic [31:0]           mp_cnt
);

    localparam int ENTRIES = 2**IDX_W;
    localparam int TAG_W   = DATA_WIDTH - IDX_W - 2;

    logic [ENTRIES-1:0]    valid_q;
    logic [TAG_W-1:0]      tag_q [ENTRIES];
    logic [DATA_WIDTH-1:0] tgt_q [ENTRIES];
    ctr_t                  ctr_q [ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;

    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic             upd;
    logic             entry_we;
    logic             tgt_we;
    logic             ctr_load;
    ctr_t             ctr_load_val;
    ctr_t             ctr_nxt;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[DATA_WIDTH-1:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[DATA_WIDTH-1:IDX_W+2];

    // Fetch-side lookup reads registered state only, so a same-cycle update is not bypassed
    always_comb begin
        if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        pred_taken  = if_hit && ctr_q[if_idx][1];
        pred_target = pred_taken ? tgt_q[if_idx] : if_pc + DATA_WIDTH'(4);
    end

    // Execute-side resolve: compare carried prediction against the real outcome
    always_comb begin
        upd         = ex_valid && (ex_is_branch || ex_is_jal);
        mispredict  = upd && ((ex_pred_taken != ex_taken) ||
                              (ex_taken && (ex_pred_target != ex_target)));
        redirect_pc = ex_taken ? ex_target : ex_pc + DATA_WIDTH'(4);
    end

    // Update decode: jal forces strong-taken; a miss only allocates when taken
    always_comb begin
        ex_hit       = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
        entry_we     = upd && (ex_hit || ex_taken);
        tgt_we       = upd && (ex_taken || (ex_hit && ex_is_jal));
        ctr_load     = ex_is_jal || !ex_hit;
        ctr_load_val = ex_is_jal ? CTR_ST : CTR_WT;
    end

    sat_counter2 u_sat_counter2 (
        .ctr_cur  (ctr_q[ex_idx]),
        .inc      (ex_taken),
        .load     (ctr_load),
        .load_val (ctr_load_val),
        .ctr_nxt  (ctr_nxt)
    );

    // Table write; reset clears everything, so an update in flight during reset is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= CTR_WNT;
            end
        end else begin
            if (entry_we) begin
                valid_q[ex_idx] <= 1'b1;
                tag_q[ex_idx]   <= ex_tag;
                ctr_q[ex_idx]   <= ctr_nxt;
            end
            if (tgt_we) begin
                tgt_q[ex_idx] <= ex_target;
            end
        end
    end

    // Performance counters: every resolved control transfer, and those that flushed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt <= '0;
            mp_cnt <= '0;
        end else if (upd) begin
            br_cnt <= br_cnt + 32'd1;
            if (mispredict) mp_cnt <= mp_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_is_branch;
    logic        ex_is_jal;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] br_cnt;
    logic [31:0] mp_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_predictor #(.DATA_WIDTH(32), .IDX_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_is_branch   (ex_is_branch),
        .ex_is_jal      (ex_is_jal),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc),
        .br_cnt         (br_cnt),
        .mp_cnt         (mp_cnt)
    );

    // Reference model: one record per slot, strength held as an integer 0..3
    bit          m_v   [16];
    int unsigned m_tag [16];
    logic [31:0] m_tgt [16];
    int          m_str [16];
    int unsigned m_br;
    int unsigned m_mp;

    function automatic int slot(input logic [31:0] pc);
        return int'((pc >> 2) % 16);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_v[slot(pc)] && (m_tag[slot(pc)] == (pc >> 6));
    endfunction

    function automatic bit m_pt(input logic [31:0] pc);
        return m_hit(pc) && (m_str[slot(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_ptg(input logic [31:0] pc);
        return m_pt(pc) ? m_tgt[slot(pc)] : pc + 32'd4;
    endfunction

    function automatic bit m_upd();
        return ex_valid && (ex_is_branch || ex_is_jal);
    endfunction

    function automatic bit m_mis();
        return m_upd() && ((ex_pred_taken != ex_taken) ||
                           (ex_taken && ex_pred_target != ex_target));
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) begin
            m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_str[i] = 1;
        end
        m_br = 0;
        m_mp = 0;
    endtask

    // Apply the resolved outcome at the clock edge, sampled from the inputs just before it
    task automatic m_update();
        int i;
        if (!m_upd()) return;
        i = slot(ex_pc);
        if (m_mis()) m_mp++;
        m_br++;
        if (m_hit(ex_pc)) begin
            if (ex_is_jal) begin
                m_str[i] = 3; m_tgt[i] = ex_target;
            end else if (ex_taken) begin
                m_str[i] = (m_str[i] == 3) ? 3 : m_str[i] + 1;
                m_tgt[i] = ex_target;
            end else begin
                m_str[i] = (m_str[i] == 0) ? 0 : m_str[i] - 1;
            end
        end else if (ex_taken) begin
            m_v[i]   = 1;
            m_tag[i] = ex_pc >> 6;
            m_tgt[i] = ex_target;
            m_str[i] = ex_is_jal ? 3 : 2;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ex_set(input bit v, input logic [31:0] pc, input bit br, input bit jal,
                          input bit t, input logic [31:0] tg, input bit pt,
                          input logic [31:0] ptg);
        ex_valid = v; ex_pc = pc; ex_is_branch = br; ex_is_jal = jal;
        ex_taken = t; ex_target = tg; ex_pred_taken = pt; ex_pred_target = ptg;
    endtask

    // One cycle: check combinational outputs, clock, update model, check counters
    task automatic step(input string tag);
        #1;
        chk({tag, ":pred_taken"}, 32'(pred_taken), 32'(m_pt(if_pc)));
        chk({tag, ":pred_target"}, pred_target, m_ptg(if_pc));
        chk({tag, ":mispredict"}, 32'(mispredict), 32'(m_mis()));
        chk({tag, ":redirect"}, redirect_pc, ex_taken ? ex_target : ex_pc + 32'd4);
        @(posedge clk);
        m_update();
        #1;
        chk({tag, ":br_cnt"}, br_cnt, m_br);
        chk({tag, ":mp_cnt"}, mp_cnt, m_mp);
    endtask

    task automatic idle();
        ex_set(0, 32'h300, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] pc;
        rst = 1'b1;
        if_pc = 32'h100;
        idle();
        m_reset();
        #12 rst = 1'b0;
        @(posedge clk); #1;

        // Out of reset
        chk("rst:pred_taken", 32'(pred_taken), 32'd0);
        chk("rst:pred_target", pred_target, 32'h104);
        chk("rst:br_cnt", br_cnt, 32'd0);
        chk("rst:mp_cnt", mp_cnt, 32'd0);
        chk("rst:mispredict", 32'(mispredict), 32'd0);
        chk("rst:redirect", redirect_pc, 32'h304);

        // First taken branch allocates and mispredicts
        ex_set(1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104);
        #1;
        chk("alloc:mispredict", 32'(mispredict), 32'd1);
        chk("alloc:redirect", redirect_pc, 32'h80);
        step("alloc");
        idle();
        #1;
        chk("alloc_next:pred_taken", 32'(pred_taken), 32'd1);
        chk("alloc_next:pred_target", pred_target, 32'h80);
        chk("alloc_next:mp_cnt", mp_cnt, 32'd1);
        step("alloc_next");

        // Two not-taken: 10 -> 01 -> 00
        ex_set(1, 32'h100, 1, 0, 0, 32'h80, 1, 32'h80);
        step("nt1");
        idle();
        #1;
        chk("nt1_after:pred_taken", 32'(pred_taken), 32'd0);
        ex_set(1, 32'h100, 1, 0, 0, 32'h80, 0, 32'h104);
        #1;
        chk("nt2:mispredict", 32'(mispredict), 32'd0);
        chk("nt2:redirect", redirect_pc, 32'h104);
        step("nt2");

        // Three taken saturate, fourth holds, one not-taken still predicts taken
        ex_set(1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104);
        step("t1");
        step("t2");
        idle();
        #1;
        chk("t2_after:pred_taken", 32'(pred_taken), 32'd1);
        ex_set(1, 32'h100, 1, 0, 1, 32'h80, 1, 32'h80);
        step("t3");
        step("t4");
        ex_set(1, 32'h100, 1, 0, 0, 32'h80, 1, 32'h80);
        step("sat_nt");
        idle();
        #1;
        chk("sat_hold:pred_taken", 32'(pred_taken), 32'd1);

        // jal allocates strong taken, then target-only mispredict
        ex_set(1, 32'h200, 0, 1, 1, 32'h400, 0, 32'h204);
        step("jal_alloc");
        idle();
        if_pc = 32'h200;
        #1;
        chk("jal:pred_taken", 32'(pred_taken), 32'd1);
        chk("jal:pred_target", pred_target, 32'h400);
        ex_set(1, 32'h200, 1, 1, 1, 32'h400, 1, 32'h3F0);
        #1;
        chk("jal_tgt:mispredict", 32'(mispredict), 32'd1);
        chk("jal_tgt:redirect", redirect_pc, 32'h400);
        step("jal_tgt");

        // Aliasing at slot 0: 0x100 allocated, then evicted by 0x140
        if_pc = 32'h100;
        ex_set(1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104);
        step("alias_a");
        ex_set(1, 32'h140, 1, 0, 1, 32'h500, 0, 32'h144);
        #1;
        chk("same_cycle:pred_taken", 32'(pred_taken), 32'd1);
        chk("same_cycle:pred_target", pred_target, 32'h80);
        step("alias_b");
        idle();
        #1;
        chk("evicted:pred_taken", 32'(pred_taken), 32'd0);
        if_pc = 32'h140;
        #1;
        chk("evictor:pred_target", pred_target, 32'h500);

        // ex_valid low: nothing moves
        ex_set(0, 32'h180, 1, 0, 1, 32'h900, 0, 32'h184);
        step("novalid");
        idle();
        if_pc = 32'h180;
        step("novalid_after");

        // Fall-through wraps around the address space
        if_pc = 32'hFFFF_FFFC;
        #1;
        chk("wrap:pred_target", pred_target, 32'h0);

        // Randomized traffic over a small, aliasing PC range
        for (int n = 0; n < 400; n++) begin
            pc = 32'h100 + ($urandom_range(0, 31) << 2) + $urandom_range(0, 3);
            ex_valid     = ($urandom_range(0, 9) < 8);
            ex_pc        = pc;
            ex_is_jal    = ($urandom_range(0, 5) == 0);
            ex_is_branch = ($urandom_range(0, 5) != 0);
            ex_taken     = $urandom_range(0, 1);
            ex_target    = 32'h1000 + ($urandom_range(0, 7) << 4);
            if ($urandom_range(0, 1) == 1) begin
                ex_pred_taken  = m_pt(pc);
                ex_pred_target = m_ptg(pc);
            end else begin
                ex_pred_taken  = $urandom_range(0, 1);
                ex_pred_target = 32'h1000 + ($urandom_range(0, 7) << 4);
            end
            if_pc = 32'h100 + ($urandom_range(0, 31) << 2) + $urandom_range(0, 3);
            step("rand");
        end

        // Asynchronous reset mid-operation with an update pending
        ex_set(1, 32'h104, 1, 0, 1, 32'h2000, 0, 32'h108);
        #2 rst = 1'b1;
        m_reset();
        for (int k = 0; k < 32; k++) begin
            if_pc = 32'h100 + 32'(k << 2);
            #1;
            chk("midrst:pred_taken", 32'(pred_taken), 32'd0);
        end
        chk("midrst:br_cnt", br_cnt, 32'd0);
        chk("midrst:mp_cnt", mp_cnt, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle();
        if_pc = 32'h104;
        step("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side producer of branch outcomes; branch_decision is the execute-side resolver of the same outcomes.
- Direct-mapped BTB with a 2-bit saturating counter per entry:
  - IF stage looks up the current PC and gets a predicted direction and target.
  - EX stage writes back the resolved outcome from branch_decision (branch_res), and the block flags a mispredict plus the redirect PC.
- Also keeps two performance counters.

Parameters:
- DATA_WIDTH, 32, PC/target width (matches `DATA_WIDTH).
- IDX_W, 4, index bits; ENTRIES = 2**IDX_W.
- TAG_W = DATA_WIDTH-IDX_W-2, derived, stored tag width.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- if_pc  in  DATA_WIDTH  fetch PC.
- pred_taken  out  1  predicted taken for if_pc.
- pred_target  out  DATA_WIDTH  predicted target (if_pc+4 when not predicted taken).
- ex_valid  in  1  EX stage holds a valid, non-flushed instruction.
- ex_pc  in  DATA_WIDTH  PC of EX instruction.
- ex_is_branch  in  1  conditional branch (branch_req).
- ex_is_jal  in  1  unconditional jump (jal_req).
- ex_taken  in  1  resolved outcome (branch_res).
- ex_target  in  DATA_WIDTH  resolved target.
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction.
- ex_pred_target  in  DATA_WIDTH  predicted target carried down the pipe.
- mispredict  out  1  flush request.
- redirect_pc  out  DATA_WIDTH  correct next PC when mispredict=1.
- br_cnt  out  32  resolved control-transfer count.
- mp_cnt  out  32  mispredict count.

Behaviour:
- Storage, per entry: valid, tag = pc[DATA_WIDTH-1:IDX_W+2], target, ctr[1:0].
- Address split: index = pc[IDX_W+1:2]; pc[1:0] ignored.
- Reset (async, all state):
  - valid=0, ctr=2'b01, target=0.
  - br_cnt=0, mp_cnt=0.
  - Outputs therefore come out of reset as pred_taken=0, pred_target=if_pc+4, mispredict=0, redirect_pc=ex_pc+4.
- Lookup (combinational, zero latency):
  - hit = valid[idx] & tag match.
  - pred_taken = hit & ctr[1].
  - pred_target = pred_taken ? target : if_pc+4, with wrap mod 2^DATA_WIDTH.
- Resolve (combinational), with upd = ex_valid & (ex_is_branch | ex_is_jal):
  - mispredict = upd & ((ex_pred_taken != ex_taken) | (ex_taken & ex_pred_target != ex_target)).
  - redirect_pc = ex_taken ? ex_target : ex_pc+4.
- Update (on clk rising edge, when upd=1; ex_pc entry hit/miss evaluated independently of the IF lookup):
  - Hit, branch: ctr increments saturating at 2'b11 if ex_taken, decrements saturating at 2'b00 otherwise; target<=ex_target if ex_taken.
  - Hit, jal: ctr<=2'b11, target<=ex_target.
  - Miss, taken: allocate and overwrite (no replacement policy) with valid=1, tag, target=ex_target, ctr = ex_is_jal ? 2'b11 : 2'b10.
  - Miss, not taken: no change.
  - br_cnt += 1; mp_cnt += mispredict. Both wrap at 2^32.
- ex_is_jal has priority over ex_is_branch if both are asserted.
- ex_valid=0: no update, mispredict=0, counters hold.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents (no bypass); the new value is visible next cycle.
- Reset mid-operation clears the table immediately; the in-flight update is lost.

Decomposition:
- Shared include (include.v): `DATA_WIDTH, and CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11, CTR_SNT=2'b00.
- One natural sub-module: sat_counter2, the 2-bit saturating inc/dec with load; instantiate per entry or once on the update path.

Test Plan:
- Reset, then if_pc=0x100 → pred_taken=0, pred_target=0x104; br_cnt=mp_cnt=0.
- Branch at ex_pc=0x100, taken, target 0x80, ex_pred_taken=0 → mispredict=1, redirect_pc=0x80. Next cycle, if_pc=0x100 → pred_taken=1, pred_target=0x80; mp_cnt=1.
- Same branch resolved not-taken twice:
  - ctr 10→01→00.
  - Prediction becomes 0 after the first not-taken; the second not-taken with ex_pred_taken=0 gives mispredict=0, redirect_pc=0x104.
  - Three taken resolutions from 00 saturate ctr at 11, and a fourth taken holds it at 11.
- jal at 0x200 → 0x400, ex_pred_taken=0 → allocate with ctr=11. A later if_pc=0x200 predicts 0x400. Resolving with ex_pred_target=0x3F0 gives mispredict=1 on the target mismatch alone.
- Aliasing: 0x100 and 0x140 with IDX_W=4 share index 0, tags differ.
  - Allocate 0x100, then a taken branch at 0x140 evicts it; if_pc=0x100 → pred_taken=0.
  - Same-cycle update and lookup at index 0 returns the old entry.
- ex_valid=0 with ex_taken=1 → no table change, counters hold. Assert rst mid-run → all pred_taken=0 asynchronously.
